// File: rtl/dma_priority_resolver.sv
// N-channel DMA request qualifier, fixed/rotating priority arbiter and HRQ/HLDA grant sequencer.
// Optional software request register is built only when DMA_SWREQ_EN is defined.
module dma_priority_resolver #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] mask,
  input  logic              dreq_active_low,
  input  logic              dack_active_high,
  input  logic              rotate_en,
  input  logic              ctrl_disable,
  input  logic              hlda,
  input  logic              xfer_done,
  input  logic              sw_req_wr,
  input  logic [CH_W-1:0]   sw_req_ch,
  input  logic              sw_req_val,
  output logic              hrq,
  output logic [NUM_CH-1:0] VALID_DREQ,
  output logic              validDACK,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   active_ch
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;

  state_t              state;
  logic [NUM_CH-1:0]   eff;
  logic [NUM_CH-1:0]   req_q;
  logic [NUM_CH-1:0]   sw_req;
  logic [NUM_CH-1:0]   grant_nxt;
  logic [CH_W-1:0]     prio_ptr;
  logic [CH_W-1:0]     ptr_rot;
  logic [CH_W-1:0]     win_ch;
  logic [CH_W-1:0]     scan_ch;
  logic                win_vld;
  logic                served;

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign eff[i] = (((DREQ[i] ^ dreq_active_low) & ~mask[i]) | sw_req[i]) & ~ctrl_disable;
  end

  // Served channel drops to lowest priority after a completed transfer.
  assign served  = (state == GRANT) && xfer_done;
  assign ptr_rot = (active_ch == CH_W'(NUM_CH - 1)) ? '0 : active_ch + CH_W'(1);

`ifdef DMA_SWREQ_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sw_req <= '0;
    end else begin
      if (served) sw_req[active_ch] <= 1'b0;
      // Later assignment lets a same-cycle write beat the auto-clear.
      if (sw_req_wr && ({1'b0, sw_req_ch} < (CH_W + 1)'(NUM_CH)))
        sw_req[sw_req_ch] <= sw_req_val;
    end
  end
`else
  assign sw_req = '0;
  wire unused_sw = ^{sw_req_wr, sw_req_ch, sw_req_val};
`endif

  always_comb begin
    win_ch  = '0;
    win_vld = 1'b0;
    scan_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_ch = wrap_add(prio_ptr, k);
      if (!win_vld && req_q[scan_ch]) begin
        win_vld = 1'b1;
        win_ch  = scan_ch;
      end
    end
  end

  always_comb begin
    grant_nxt = '0;
    case (state)
      REQ:     if (win_vld && hlda) grant_nxt[win_ch] = 1'b1;
      GRANT:   if (!xfer_done && hlda) grant_nxt = VALID_DREQ;
      default: grant_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      hrq        <= 1'b0;
      VALID_DREQ <= '0;
      validDACK  <= 1'b0;
      active_ch  <= '0;
      prio_ptr   <= '0;
      req_q      <= '0;
      DACK       <= {NUM_CH{~dack_active_high}};
    end else begin
      req_q      <= eff;
      VALID_DREQ <= grant_nxt;
      DACK       <= grant_nxt ^ {NUM_CH{~dack_active_high}};
      if (!rotate_en)  prio_ptr <= '0;
      else if (served) prio_ptr <= ptr_rot;
      case (state)
        IDLE: if (win_vld) begin
          state <= REQ;
          hrq   <= 1'b1;
        end
        REQ: if (!win_vld) begin
          state <= IDLE;
          hrq   <= 1'b0;
        end else if (hlda) begin
          state     <= GRANT;
          validDACK <= 1'b1;
          active_ch <= win_ch;
        end
        // Completion and HLDA abort share the drop; only completion rotates.
        GRANT: if (xfer_done || !hlda) begin
          state     <= IDLE;
          hrq       <= 1'b0;
          validDACK <= 1'b0;
          active_ch <= '0;
        end
        default: begin
          state <= IDLE;
          hrq   <= 1'b0;
        end
      endcase
    end
  end

endmodule
